// File: rtl/multi_channel_clock_divider.sv
// rtl/multi_channel_clock_divider.sv - N-channel programmable divider producing clock enables and square waves
module multi_channel_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 50,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // A write is only accepted when it addresses an existing channel.
  logic cfg_valid;
  assign cfg_valid = cfg_we && (32'(cfg_ch) < NUM_CH);

  // Write handshake: ack for accepted writes, err for out-of-range channel.
  always_ff @(posedge clk100) begin
    if (reset) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_valid;
      cfg_err <= cfg_we && !cfg_valid;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_div_nxt;
    logic [CNT_W-1:0] eff_div;
    logic             mode;
    logic             sh_mode;
    logic             sh_mode_nxt;
    logic             wr_hit;
    logic             terminal;
    logic             tick_q;
    logic             clk_q;

    // Shadow values as they will be after this cycle, so a write that lands
    // on a commit point (terminal count or sync_clr) is taken immediately.
    // Terminal uses >= so a counter left above a shrunken divisor while the
    // channel was disabled wraps on the first enabled cycle.
    always_comb begin
      wr_hit      = cfg_valid && (cfg_ch == CH_W'(i));
      sh_div_nxt  = wr_hit ? cfg_div  : sh_div;
      sh_mode_nxt = wr_hit ? cfg_mode : sh_mode;
      eff_div     = (div == '0) ? ONE : div;
      terminal    = (cnt >= eff_div - ONE);
    end

    // Per-channel counter, active config commit and output waveform.
    always_ff @(posedge clk100) begin
      if (reset) begin
        cnt     <= '0;
        div     <= DIV_RST;
        sh_div  <= DIV_RST;
        mode    <= 1'b0;
        sh_mode <= 1'b0;
        tick_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else if (sync_clr) begin
        cnt     <= '0;
        tick_q  <= 1'b0;
        clk_q   <= 1'b0;
        sh_div  <= sh_div_nxt;
        sh_mode <= sh_mode_nxt;
        div     <= sh_div_nxt;
        mode    <= sh_mode_nxt;
      end else if (ch_en[i]) begin
        sh_div  <= sh_div_nxt;
        sh_mode <= sh_mode_nxt;
        if (terminal) begin
          // Commit at the period boundary so clk_out never shows a runt.
          cnt    <= '0;
          tick_q <= 1'b1;
          div    <= sh_div_nxt;
          mode   <= sh_mode_nxt;
          clk_q  <= sh_mode_nxt ? 1'b1 : ~clk_q;
        end else begin
          cnt    <= cnt + ONE;
          tick_q <= 1'b0;
          clk_q  <= mode ? 1'b0 : clk_q;
        end
      end else begin
        // Stopped channel: counter frozen, config takes effect at once.
        tick_q  <= 1'b0;
        sh_div  <= sh_div_nxt;
        sh_mode <= sh_mode_nxt;
        div     <= sh_div_nxt;
        mode    <= sh_mode_nxt;
        clk_q   <= sh_mode_nxt ? 1'b0 : clk_q;
      end
    end

    assign tick[i]    = tick_q;
    assign clk_out[i] = clk_q;
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// tb/tb_multi_channel_clock_divider.sv - directed self-checking bench for multi_channel_clock_divider
module tb_multi_channel_clock_divider;

  localparam int NCH   = 3;
  localparam int CW    = 27;
  localparam int LIMIT = 200;

  logic           clk100 = 1'b0;
  logic           reset;
  logic [NCH-1:0] ch_en;
  logic           sync_clr;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;
  logic           cfg_ack;
  logic           cfg_err;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;

  int checks = 0;
  int errors = 0;
  int n;

  multi_channel_clock_divider #(
    .NUM_CH(NCH),
    .CNT_W(CW),
    .DEFAULT_DIV(50)
  ) dut (
    .clk100(clk100),
    .reset(reset),
    .ch_en(ch_en),
    .sync_clr(sync_clr),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .cfg_ack(cfg_ack),
    .cfg_err(cfg_err),
    .tick(tick),
    .clk_out(clk_out)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk100);
  endtask

  // Number of cycles until tick[ch] is seen high (bounded).
  task automatic wait_tick(input int ch, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk100);
      cnt++;
    end while (!tick[ch] && cnt < LIMIT);
  endtask

  // Drive a one-cycle write; returns on the cycle where ack/err is visible.
  task automatic cfg_write(input int ch, input int dv, input logic md);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_div  = CW'(dv);
    cfg_mode = md;
    @(negedge clk100);
    cfg_we   = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    ch_en    = 3'b111;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_mode = 1'b0;
    cycles(3);
    check("rst_tick", tick, 0);
    check("rst_clk", clk_out, 0);
    check("rst_ack", cfg_ack, 0);
    check("rst_err", cfg_err, 0);
    reset = 1'b0;

    // T1: default cadence
    wait_tick(0, n);
    check("t1_first_tick", n, 50);
    check("t1_all_tick", tick, 3'b111);
    check("t1_clk_hi", clk_out, 3'b111);
    wait_tick(0, n);
    check("t1_second_tick", n, 50);
    check("t1_clk_lo", clk_out, 3'b000);

    // T2: ch1 -> div 3 pulse mode, mid-period
    cycles(10);
    cfg_write(1, 3, 1'b1);
    check("t2_ack", cfg_ack, 1);
    check("t2_no_err", cfg_err, 0);
    cycles(1);
    check("t2_ack_pulse", cfg_ack, 0);
    wait_tick(1, n);
    check("t2_old_period", n, 38);
    check("t2_all_tick", tick, 3'b111);
    check("t2_clk_commit", clk_out, 3'b111);
    for (int j = 1; j <= 6; j++) begin
      cycles(1);
      check("t2_tick1", tick[1], (j % 3 == 0) ? 1 : 0);
      check("t2_clk1", clk_out[1], (j % 3 == 0) ? 1 : 0);
    end

    // T3: ch2 -> div 0 (treated as 1), toggle mode
    cfg_write(2, 0, 1'b0);
    check("t3_ack", cfg_ack, 1);
    wait_tick(2, n);
    check("t3_old_period", n, 43);
    check("t3_clk_commit", clk_out[2], 0);
    for (int j = 1; j <= 6; j++) begin
      cycles(1);
      check("t3_tick2", tick[2], 1);
      check("t3_clk2", clk_out[2], j % 2);
    end

    // T4: ch0 paused at cnt=20 for 10 cycles
    cycles(14);
    ch_en[0] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cycles(1);
      check("t4_frozen_tick", tick[0], 0);
      check("t4_frozen_clk", clk_out[0], 0);
    end
    ch_en[0] = 1'b1;
    wait_tick(0, n);
    check("t4_resume", n, 30);
    check("t4_clk0", clk_out[0], 1);

    // T5: pending writes then sync_clr with a simultaneous write
    cycles(5);
    cfg_write(1, 50, 1'b0);
    cfg_we   = 1'b1;
    cfg_ch   = 2'd2;
    cfg_div  = CW'(50);
    cfg_mode = 1'b0;
    sync_clr = 1'b1;
    @(negedge clk100);
    cfg_we   = 1'b0;
    sync_clr = 1'b0;
    check("t5_clk_clr", clk_out, 3'b000);
    check("t5_tick_clr", tick, 3'b000);
    check("t5_ack", cfg_ack, 1);
    wait_tick(0, n);
    check("t5_aligned_period", n, 50);
    check("t5_all_tick", tick, 3'b111);
    check("t5_all_clk", clk_out, 3'b111);

    // T6: invalid channel write
    cfg_write(3, 5, 1'b1);
    check("t6_err", cfg_err, 1);
    check("t6_no_ack", cfg_ack, 0);
    cycles(1);
    check("t6_err_pulse", cfg_err, 0);
    wait_tick(0, n);
    check("t6_period_kept", n, 48);
    check("t6_all_tick", tick, 3'b111);

    // Reset mid-period discards a pending config
    cycles(5);
    cfg_write(0, 7, 1'b0);
    check("rst_pend_ack", cfg_ack, 1);
    cycles(10);
    reset = 1'b1;
    cycles(1);
    check("mid_rst_tick", tick, 0);
    check("mid_rst_clk", clk_out, 0);
    reset = 1'b0;
    wait_tick(0, n);
    check("mid_rst_first", n, 50);
    check("mid_rst_all_tick", tick, 3'b111);
    wait_tick(0, n);
    check("mid_rst_second", n, 50);
    check("mid_rst_clk_lo", clk_out, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
